// File: rtl/core_scheduler.sv
// Per-core instruction sequencer: FETCH/DECODE/REQUEST/WAIT/EXECUTE/UPDATE with RET completion.
// Optional lane-PC divergence detection is built when CORE_SCHED_DIVERGENCE_CHECK_EN is defined.
module core_scheduler #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int THREADS_PER_BLOCK     = 4
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start,
  input  logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
  input  logic [2:0]                                         fetcher_state,
  input  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state,
  input  logic                                               decoded_ret,
  input  logic [THREADS_PER_BLOCK*PROGRAM_MEM_ADDR_BITS-1:0] next_pc,
  output logic [2:0]                                         core_state,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
  output logic                                               done,
  output logic                                               diverged
);

  localparam int W = PROGRAM_MEM_ADDR_BITS;
  localparam int T = THREADS_PER_BLOCK;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_FETCH   = 3'b001,
    S_DECODE  = 3'b010,
    S_REQUEST = 3'b011,
    S_WAIT    = 3'b100,
    S_EXECUTE = 3'b101,
    S_UPDATE  = 3'b110,
    S_DONE    = 3'b111
  } state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  state_t         state_q, state_d;
  logic [W-1:0]   current_pc_q, current_pc_d;
  logic           done_q, done_d;
  logic           diverged_q, diverged_d;
  logic [W-1:0]   sel_pc;
  logic           lsu_busy;
  logic           lane_mismatch;

  // An enabled lane still requesting or waiting on memory holds the core in WAIT.
  always_comb begin
    lsu_busy = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (thread_enable[i] &&
          ((lsu_state[2*i +: 2] == 2'b01) || (lsu_state[2*i +: 2] == 2'b10)))
        lsu_busy = 1'b1;
    end
  end

  // Lowest-index enabled lane wins; lane 0 when no lane is enabled.
  always_comb begin
    sel_pc = next_pc[0 +: W];
    for (int i = T - 1; i >= 0; i--) begin
      if (thread_enable[i])
        sel_pc = next_pc[i*W +: W];
    end
  end

`ifdef CORE_SCHED_DIVERGENCE_CHECK_EN
  always_comb begin
    lane_mismatch = 1'b0;
    for (int i = 0; i < T; i++) begin
      if (thread_enable[i] && (next_pc[i*W +: W] != sel_pc))
        lane_mismatch = 1'b1;
    end
  end
`else
  assign lane_mismatch = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      current_pc_q <= '0;
      done_q       <= 1'b0;
      diverged_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      current_pc_q <= current_pc_d;
      done_q       <= done_d;
      diverged_q   <= diverged_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start) state_d = S_FETCH;
      S_FETCH:   if (fetcher_state == FETCHER_FETCHED) state_d = S_DECODE;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      S_WAIT:    if (!lsu_busy) state_d = S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE:  state_d = (decoded_ret || lane_mismatch) ? S_DONE : S_FETCH;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    current_pc_d = current_pc_q;
    done_d       = done_q;
    diverged_d   = diverged_q;
    case (state_q)
      S_IDLE: begin
        if (start) current_pc_d = '0;
      end
      S_UPDATE: begin
        if (decoded_ret) begin
          done_d = 1'b1;
        end else if (lane_mismatch) begin
          done_d     = 1'b1;
          diverged_d = 1'b1;
        end else begin
          current_pc_d = sel_pc;
        end
      end
      default: ;
    endcase
  end

  assign core_state = state_q;
  assign current_pc = current_pc_q;
  assign done       = done_q;
  assign diverged   = diverged_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: straight-line run, LSU stall, branch, reset, divergence, fetch stall.
module tb_core_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  thread_enable;
  logic [2:0]  fetcher_state;
  logic [7:0]  lsu_state;
  logic        decoded_ret;
  logic [31:0] next_pc;
  logic [2:0]  core_state;
  logic [7:0]  current_pc;
  logic        done;
  logic        diverged;

  int checks = 0;
  int errors = 0;

  core_scheduler #(
    .PROGRAM_MEM_ADDR_BITS(8),
    .THREADS_PER_BLOCK(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .thread_enable(thread_enable),
    .fetcher_state(fetcher_state),
    .lsu_state    (lsu_state),
    .decoded_ret  (decoded_ret),
    .next_pc      (next_pc),
    .core_state   (core_state),
    .current_pc   (current_pc),
    .done         (done),
    .diverged     (diverged)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] st, input logic [7:0] pc,
                           input logic dn, input logic dv);
    check({tag, ".state"}, 32'(core_state), 32'(st));
    check({tag, ".pc"},    32'(current_pc), 32'(pc));
    check({tag, ".done"},  32'(done),       32'(dn));
    check({tag, ".div"},   32'(diverged),   32'(dv));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic launch(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_all({tag, ".launch"}, 3'b001, 8'h00, 1'b0, 1'b0);
  endtask

  // From FETCH with the fetcher reporting FETCHED and no memory traffic, walk to EXECUTE.
  task automatic run_to_exec(input string tag);
    tick(); check({tag, ".dec"},  32'(core_state), 32'(3'b010));
    tick(); check({tag, ".req"},  32'(core_state), 32'(3'b011));
    tick(); check({tag, ".wait"}, 32'(core_state), 32'(3'b100));
    tick(); check({tag, ".exe"},  32'(core_state), 32'(3'b101));
  endtask

  // Present lane PCs in EXECUTE, pass through UPDATE, then check the resulting state.
  task automatic update(input string tag, input logic [31:0] npc, input logic ret,
                        input logic [2:0] st, input logic [7:0] pc, input logic dn, input logic dv);
    next_pc     = npc;
    decoded_ret = ret;
    tick(); check({tag, ".upd"}, 32'(core_state), 32'(3'b110));
    tick(); check_all({tag, ".after"}, st, pc, dn, dv);
    decoded_ret = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    thread_enable = 4'b1111;
    fetcher_state = 3'b000;
    lsu_state     = 8'h00;
    decoded_ret   = 1'b0;
    next_pc       = 32'h0;
    tick();
    tick();
    check_all("reset", 3'b000, 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_all("idle_hold", 3'b000, 8'h00, 1'b0, 1'b0);

    // Straight-line program, RET at PC 3
    fetcher_state = 3'b010;
    launch("line");
    run_to_exec("line0"); update("line0", {4{8'h01}}, 1'b0, 3'b001, 8'h01, 1'b0, 1'b0);
    run_to_exec("line1"); update("line1", {4{8'h02}}, 1'b0, 3'b001, 8'h02, 1'b0, 1'b0);
    run_to_exec("line2"); update("line2", {4{8'h03}}, 1'b0, 3'b001, 8'h03, 1'b0, 1'b0);
    run_to_exec("line3"); update("line3", {4{8'h04}}, 1'b1, 3'b111, 8'h03, 1'b1, 1'b0);
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_all("done_hold", 3'b111, 8'h03, 1'b1, 1'b0);
    end
    start = 1'b0;

    // LSU stall on enabled lane 2
    do_reset();
    check_all("reset2", 3'b000, 8'h00, 1'b0, 1'b0);
    launch("stall");
    tick(); check("stall.dec", 32'(core_state), 32'(3'b010));
    tick(); check("stall.req", 32'(core_state), 32'(3'b011));
    lsu_state = 8'b00_10_00_00;
    tick(); check("stall.wait0", 32'(core_state), 32'(3'b100));
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stall.waitn", 32'(core_state), 32'(3'b100));
      check("stall.pc",    32'(current_pc), 32'(8'h00));
    end
    lsu_state = 8'b00_11_00_00;
    tick(); check("stall.exe", 32'(core_state), 32'(3'b101));
    update("stall", {4{8'h01}}, 1'b0, 3'b001, 8'h01, 1'b0, 1'b0);

    // Same busy lane, but disabled: WAIT lasts one cycle
    do_reset();
    thread_enable = 4'b1011;
    lsu_state     = 8'b00_10_00_00;
    launch("masked");
    run_to_exec("masked");
    update("masked", {4{8'h07}}, 1'b0, 3'b001, 8'h07, 1'b0, 1'b0);
    lsu_state = 8'h00;

    // Branch taken from lane 0
    do_reset();
    thread_enable = 4'b1111;
    launch("br0");
    run_to_exec("br0");
    update("br0", {4{8'h20}}, 1'b0, 3'b001, 8'h20, 1'b0, 1'b0);

    // Mask 1100: lane 2 is the lowest enabled lane
    do_reset();
    thread_enable = 4'b1100;
    launch("br2");
    run_to_exec("br2");
    update("br2", {8'h44, 8'h44, 8'h11, 8'h11}, 1'b0, 3'b001, 8'h44, 1'b0, 1'b0);

    // Reset while stalled in WAIT
    lsu_state = 8'b00_01_00_00;
    tick(); tick(); tick();
    check("rstw.wait", 32'(core_state), 32'(3'b100));
    tick();
    check("rstw.wait2", 32'(core_state), 32'(3'b100));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all("rstw.after", 3'b000, 8'h00, 1'b0, 1'b0);
    lsu_state     = 8'h00;
    thread_enable = 4'b1111;
    launch("restart");

    // Lanes 0 and 1 disagree (5 vs 9)
    run_to_exec("div");
`ifdef CORE_SCHED_DIVERGENCE_CHECK_EN
    update("div", {8'h05, 8'h05, 8'h09, 8'h05}, 1'b0, 3'b111, 8'h00, 1'b1, 1'b1);
    start = 1'b1;
    tick();
    check_all("div.hold", 3'b111, 8'h00, 1'b1, 1'b1);
    start = 1'b0;
`else
    update("div", {8'h05, 8'h05, 8'h09, 8'h05}, 1'b0, 3'b001, 8'h05, 1'b0, 1'b0);
`endif

    // Fetch stall: FETCH holds for 10 cycles with PC stable
    do_reset();
    fetcher_state = 3'b000;
    launch("fstall");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("fstall.state", 32'(core_state), 32'(3'b001));
      check("fstall.pc",    32'(current_pc), 32'(8'h00));
    end
    fetcher_state = 3'b010;
    tick();
    check("fstall.dec", 32'(core_state), 32'(3'b010));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
